// File: rtl/dual_rail_imem_responder.sv
// Clocked responder for a dual-rail (NULL/DATA) instruction-address bus: looks up a
// 16-entry instruction store and returns the word as dual-rail DATA under a four-phase handshake.
module dual_rail_imem_responder #(
  parameter int AW          = 4,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_t,
  input  logic [AW-1:0] addr_f,
  output logic          ko,
  output logic [DW-1:0] data_t,
  output logic [DW-1:0] data_f,
  input  logic          ki,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          err,
  input  logic          err_clr,
  output logic [1:0]    dbg_state
);

  // dbg_state encoding: 0 NULL, 1 READ, 2 DATA, 3 RTZ
  typedef enum logic [1:0] {
    S_NULL = 2'd0,
    S_READ = 2'd1,
    S_DATA = 2'd2,
    S_RTZ  = 2'd3
  } state_t;

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0]          sync_t [SYNC_STAGES];
  logic [AW-1:0]          sync_f [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sync_ki;
  logic [DW-1:0]          mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] lat_q, lat_d;
  logic [DW-1:0] data_t_d, data_f_d;
  logic          ko_d, err_d;

  logic [AW-1:0] cur_t, cur_f, ahead_t, ahead_f;
  logic          ki_s, illegal, complete, is_null, stable;
  logic [DW-1:0] rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_t[i] <= '0;
        sync_f[i] <= '0;
      end
      sync_ki <= '0;
    end else begin
      sync_t[0] <= addr_t;
      sync_f[0] <= addr_f;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_t[i] <= sync_t[i-1];
        sync_f[i] <= sync_f[i-1];
      end
      sync_ki <= {sync_ki[SYNC_STAGES-2:0], ki};
    end
  end

  // The last stage is the synced sample; the stage before it is the next synced sample,
  // so comparing the two qualifies stability without an extra cycle of latency.
  assign cur_t    = sync_t[SYNC_STAGES-1];
  assign cur_f    = sync_f[SYNC_STAGES-1];
  assign ahead_t  = sync_t[SYNC_STAGES-2];
  assign ahead_f  = sync_f[SYNC_STAGES-2];
  assign ki_s     = sync_ki[SYNC_STAGES-1];
  assign illegal  = |(cur_t & cur_f);
  assign complete = &(cur_t ^ cur_f);
  assign is_null  = ~|(cur_t | cur_f);
  assign stable   = (cur_t == ahead_t) && (cur_f == ahead_f);
  assign rd_word  = mem[lat_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    data_t_d = data_t;
    data_f_d = data_f;
    ko_d     = ko;
    err_d    = illegal | (err & ~err_clr);
    if (!illegal) begin
      unique case (state_q)
        S_NULL: if (complete && stable && ki_s) begin
          lat_d   = cur_t;
          state_d = S_READ;
        end
        S_READ: begin
          data_t_d = rd_word;
          data_f_d = ~rd_word;
          ko_d     = 1'b0;
          state_d  = S_DATA;
        end
        S_DATA: if (!ki_s && is_null) begin
          data_t_d = '0;
          data_f_d = '0;
          state_d  = S_RTZ;
        end
        S_RTZ: if (ki_s) begin
          ko_d    = 1'b1;
          state_d = S_NULL;
        end
        default: state_d = S_NULL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NULL;
      lat_q   <= '0;
      data_t  <= '0;
      data_f  <= '0;
      ko      <= 1'b1;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      data_t  <= data_t_d;
      data_f  <= data_f_d;
      ko      <= ko_d;
      err     <= err_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dual_rail_imem_responder.sv
// Bench for dual_rail_imem_responder: directed handshakes with literal expectations, then
// randomized traffic compared every cycle against a pin-history reference model.
module tb_dual_rail_imem_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr_t = '0, addr_f = '0;
  logic       ko;
  logic [7:0] data_t, data_f;
  logic       ki = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       err;
  logic       err_clr = 1'b0;
  logic [1:0] dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  bit cmp_on  = 1'b0;

  dual_rail_imem_responder #(.AW(4), .DW(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr_t(addr_t), .addr_f(addr_f), .ko(ko),
    .data_t(data_t), .data_f(data_f), .ki(ki), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The responder reacts to what the pins showed two and one edges ago (two-stage sync).
  logic [7:0] m_mem [16];
  logic [3:0] h_t [2], h_f [2];
  logic       h_ki [2];
  int         m_phase;  // 0 idle, 1 reading, 2 data out, 3 returning to zero
  logic [3:0] m_lat;
  logic [7:0] m_dt, m_df;
  logic       m_ko, m_err;
  logic [3:0] v_t, v_f, n_t, n_f;
  logic       v_ki, v_bad;
  int         v_ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      for (int i = 0; i < 2; i++) begin h_t[i] = '0; h_f[i] = '0; h_ki[i] = 1'b0; end
      m_phase = 0; m_lat = '0; m_dt = '0; m_df = '0; m_ko = 1'b1; m_err = 1'b0;
    end else begin
      v_t = h_t[1]; v_f = h_f[1]; v_ki = h_ki[1]; n_t = h_t[0]; n_f = h_f[0];
      v_bad = 1'b0;
      v_ones = 0;
      for (int b = 0; b < 4; b++) begin
        if (v_t[b] && v_f[b]) v_bad = 1'b1;
        if (v_t[b] != v_f[b]) v_ones++;
      end
      if (v_bad) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (!v_bad) begin
        case (m_phase)
          0: if (v_ones == 4 && v_t == n_t && v_f == n_f && v_ki) begin
               m_lat = v_t; m_phase = 1;
             end
          1: begin m_dt = m_mem[m_lat]; m_df = ~m_mem[m_lat]; m_ko = 1'b0; m_phase = 2; end
          2: if (!v_ki && v_t == 4'h0 && v_f == 4'h0) begin
               m_dt = '0; m_df = '0; m_phase = 3;
             end
          default: if (v_ki) begin m_ko = 1'b1; m_phase = 0; end
        endcase
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      h_t[1] = h_t[0]; h_f[1] = h_f[0]; h_ki[1] = h_ki[0];
      h_t[0] = addr_t; h_f[0] = addr_f; h_ki[0] = ki;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      chk("cyc_data_t", {24'h0, data_t}, {24'h0, m_dt});
      chk("cyc_data_f", {24'h0, data_f}, {24'h0, m_df});
      chk("cyc_ko", {31'h0, ko}, {31'h0, m_ko});
      chk("cyc_err", {31'h0, err}, {31'h0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic set_addr(input logic [3:0] a);
    addr_t = a; addr_f = ~a;
  endtask

  task automatic set_null();
    addr_t = '0; addr_f = '0;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rtz();
    set_null(); ki = 1'b0;
    step(3);
    ki = 1'b1;
    step(3);
  endtask

  task automatic rstep(input int n);
    repeat (n) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 8'($urandom_range(0, 255));
      err_clr = ($urandom_range(0, 7) == 0);
      step(1);
    end
    wr_en = 1'b0; err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a, g;
    int b;
    step(2);
    chk("rst_ko", {31'h0, ko}, 32'h1);
    chk("rst_data_t", {24'h0, data_t}, 32'h0);
    chk("rst_data_f", {24'h0, data_f}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    ki = 1'b1;
    load(4'h5, 8'hA7);
    load(4'h7, 8'h96);
    load(4'h2, 8'h11);
    step(2);

    // T1: DATA on the 4th edge
    set_addr(4'h5);
    step(3);
    chk("t1_early", {24'h0, data_t}, 32'h0);
    step(1);
    chk("t1_data_t", {24'h0, data_t}, 32'hA7);
    chk("t1_data_f", {24'h0, data_f}, 32'h58);
    chk("t1_ko", {31'h0, ko}, 32'h0);

    // T2: NULL on the 3rd edge, then ko, then address F
    set_null(); ki = 1'b0;
    step(2);
    chk("t2_hold", {24'h0, data_t}, 32'hA7);
    step(1);
    chk("t2_null_t", {24'h0, data_t}, 32'h0);
    chk("t2_null_f", {24'h0, data_f}, 32'h0);
    ki = 1'b1;
    step(2);
    chk("t2_ko_low", {31'h0, ko}, 32'h0);
    step(1);
    chk("t2_ko_high", {31'h0, ko}, 32'h1);
    set_addr(4'hF);
    step(4);
    chk("t2_f_data_t", {24'h0, data_t}, 32'h00);
    chk("t2_f_data_f", {24'h0, data_f}, 32'hFF);
    rtz();
    chk("t2_rtz_ko", {31'h0, ko}, 32'h1);

    // T3: illegal pair on bit 2
    addr_t = 4'b0100; addr_f = 4'b0100;
    step(3);
    chk("t3_err", {31'h0, err}, 32'h1);
    chk("t3_state", {30'h0, dbg_state}, 32'h0);
    chk("t3_data_t", {24'h0, data_t}, 32'h0);
    set_null(); err_clr = 1'b1;
    step(1);
    chk("t3_err_sticky", {31'h0, err}, 32'h1);
    step(3);
    chk("t3_err_clr", {31'h0, err}, 32'h0);
    err_clr = 1'b0;
    step(2);

    // T4: glitch 3 -> 7
    set_addr(4'h3);
    step(1);
    set_addr(4'h7);
    step(3);
    chk("t4_no_capture", {24'h0, data_t}, 32'h0);
    step(1);
    chk("t4_data_t", {24'h0, data_t}, 32'h96);
    chk("t4_data_f", {24'h0, data_f}, 32'h69);
    rtz();

    // T5: write to the latched address during the read cycle
    set_addr(4'h2);
    step(3);
    wr_en = 1'b1; wr_addr = 4'h2; wr_data = 8'h3C;
    step(1);
    wr_en = 1'b0;
    chk("t5_old", {24'h0, data_t}, 32'h11);
    rtz();
    set_addr(4'h2);
    step(4);
    chk("t5_new", {24'h0, data_t}, 32'h3C);
    rtz();

    // T6: reset while DATA is out
    set_addr(4'h5);
    step(5);
    chk("t6_pre", {24'h0, data_t}, 32'hA7);
    rst_n = 1'b0;
    #1;
    chk("t6_data_t", {24'h0, data_t}, 32'h0);
    chk("t6_data_f", {24'h0, data_f}, 32'h0);
    chk("t6_ko", {31'h0, ko}, 32'h1);
    chk("t6_err", {31'h0, err}, 32'h0);
    step(1);
    set_null(); ki = 1'b1;
    rst_n = 1'b1;
    step(3);
    set_addr(4'h5);
    step(4);
    chk("t6_cleared_t", {24'h0, data_t}, 32'h00);
    chk("t6_cleared_f", {24'h0, data_f}, 32'hFF);
    rtz();

    // randomized traffic, checked each cycle by the model
    for (int n = 0; n < 150; n++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        g = 4'($urandom_range(0, 15));
        b = $urandom_range(0, 3);
        addr_t = g; addr_f = ~g;
        addr_t[b] = 1'b1; addr_f[b] = 1'b1;
        rstep($urandom_range(1, 3));
        set_null();
        rstep(3);
      end
      if ($urandom_range(0, 4) == 0) begin
        set_addr(4'($urandom_range(0, 15)));
        rstep(1);
      end
      set_addr(a);
      rstep($urandom_range(4, 7));
      set_null();
      rstep($urandom_range(0, 2));
      ki = 1'b0;
      rstep($urandom_range(3, 5));
      ki = 1'b1;
      rstep($urandom_range(3, 5));
    end

    step(2);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
